// File: rtl/reg_arb_pkg.sv
// Shared constants for the register write-port arbiter.
// State encoding, default data width and burst counter width.
package reg_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam int DW_DEF = 32;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first eligible index at or after ptr, wrapping around.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   index,
    output logic            valid
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!valid && eligible[j]) begin
                valid     = 1'b1;
                index     = PW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the write port of one shared register.
// Supports bounded locked bursts; all outputs are registered.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               wen,
    output logic [DW-1:0]      wdata,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]      state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   owner, owner_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [NREQ-1:0] mask, mask_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic            wen_q;
    logic [DW-1:0]   wdata_q, wdata_n;

    logic [DW-1:0]   words [NREQ];
    logic [NREQ-1:0] own_oh, excl, elig;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_ok;
    logic            in_lock, own_req, own_lock, cap;
    logic            arb;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            words[i] = req_data[i*DW +: DW];
        end
    end

    assign in_lock  = (state == ST_LOCK);
    assign own_oh   = {{(NREQ-1){1'b0}}, 1'b1} << owner;
    assign own_req  = req[owner];
    assign own_lock = lock[owner];
    assign cap      = (cnt >= CNT_W'(MAX_LOCK));

    // A burst hitting its cap steps aside for this edge's arbitration.
    assign excl = (in_lock && own_req && cap) ? own_oh : '0;
    assign elig = req & ~mask & ~excl;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .eligible (elig),
        .ptr      (ptr),
        .onehot   (pick_oh),
        .index    (pick_idx),
        .valid    (pick_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            mask    <= '0;
            gnt_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            cnt     <= cnt_n;
            mask    <= mask_n;
            gnt_q   <= gnt_n;
            wen_q   <= |gnt_n;
            wdata_q <= wdata_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        mask_n  = '0;
        gnt_n   = '0;
        wdata_n = wdata_q;
        arb     = 1'b1;
        if (in_lock && own_req && !cap) begin
            arb     = 1'b0;
            gnt_n   = own_oh;
            wdata_n = words[owner];
            if (own_lock) begin
                cnt_n = cnt + 1'b1;
            end else begin
                state_n = ST_GRANT;
                cnt_n   = '0;
                mask_n  = own_oh;
            end
        end
        if (arb) begin
            if (!pick_ok) begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                mask_n  = excl;
            end else begin
                gnt_n   = pick_oh;
                wdata_n = words[pick_idx];
                owner_n = pick_idx;
                ptr_n   = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
                if (lock[pick_idx]) begin
                    state_n = ST_LOCK;
                    cnt_n   = CNT_W'(1);
                    mask_n  = excl;
                end else begin
                    state_n = ST_GRANT;
                    cnt_n   = '0;
                    mask_n  = pick_oh;
                end
            end
        end
    end

    always_comb begin
        gnt   = gnt_q;
        wen   = wen_q;
        wdata = wdata_q;
        busy  = in_lock;
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed vectors, a behavioural model
// checked every falling edge, and literal expectations per scenario.
module tb_reg_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               wen;
    logic [DW-1:0]      wdata;
    logic               busy;

    int total;
    int bad;

    reg_wr_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .req_data (req_data),
        .gnt      (gnt),
        .wen      (wen),
        .wdata    (wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared register: async clear, captures on the falling edge.
    logic [DW-1:0] shreg;
    always @(negedge clk or negedge rst) begin
        if (!rst) shreg <= '0;
        else if (wen) shreg <= wdata;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns a burst, how long it has run,
    // who is barred next time and where the search starts.
    int          m_owner;
    int          m_burst;
    int          m_blocked;
    int          m_next;
    logic [3:0]  e_gnt;
    logic [31:0] e_wdata;
    bit          e_busy;

    function automatic logic [31:0] word_of(int i);
        return req_data[i*DW +: DW];
    endfunction

    task automatic model_step();
        int o, w, cand, barred, i;
        bit rearb;
        if (!rst) begin
            m_owner = -1; m_burst = 0; m_blocked = -1; m_next = 0;
            e_gnt = '0; e_wdata = '0; e_busy = 0;
            return;
        end
        e_gnt = '0;
        rearb = 1;
        cand  = -1;
        if (m_owner >= 0) begin
            o = m_owner;
            if (!req[o]) begin
                m_owner = -1;
            end else if (m_burst == MAX_LOCK) begin
                cand    = o;
                m_owner = -1;
            end else if (!lock[o]) begin
                rearb     = 0;
                e_gnt[o]  = 1'b1;
                e_wdata   = word_of(o);
                m_owner   = -1;
                m_blocked = o;
            end else begin
                rearb     = 0;
                e_gnt[o]  = 1'b1;
                e_wdata   = word_of(o);
                m_burst   = m_burst + 1;
                m_blocked = -1;
            end
        end
        if (rearb) begin
            barred    = m_blocked;
            m_blocked = cand;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                i = (m_next + k) % NREQ;
                if (w < 0 && req[i] && i != barred && i != cand) w = i;
            end
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                e_wdata  = word_of(w);
                m_next   = (w + 1) % NREQ;
                if (lock[w]) begin
                    m_owner = w;
                    m_burst = 1;
                end else begin
                    m_blocked = w;
                end
            end
        end
        e_busy = (m_owner >= 0);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_gnt", {28'd0, gnt}, {28'd0, e_gnt});
            chk("model_wen", {31'd0, wen}, {31'd0, |e_gnt});
            chk("model_wdata", wdata, e_wdata);
            chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
        end
    end

    task automatic set_word(input int i, input logic [31:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        lock = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic see(input string name, input logic [3:0] g,
                       input logic [31:0] d, input bit b);
        chk({name, "_gnt"}, {28'd0, gnt}, {28'd0, g});
        chk({name, "_wen"}, {31'd0, wen}, {31'd0, |g});
        if (g != 0) chk({name, "_wdata"}, wdata, d);
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        req      = '0;
        lock     = '0;
        req_data = '0;
        #12;
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // single one-shot requester held for three cycles
        set_word(1, 32'hDEADBEEF);
        drive(4'b0010, 4'b0000);
        see("one_c1", 4'b0010, 32'hDEADBEEF, 0);
        drive(4'b0010, 4'b0000);
        see("one_c2", 4'b0000, 32'h0, 0);
        chk("one_reg", shreg, 32'hDEADBEEF);
        drive(4'b0010, 4'b0000);
        see("one_c3", 4'b0010, 32'hDEADBEEF, 0);
        drive(4'b0000, 4'b0000);
        see("one_c4", 4'b0000, 32'h0, 0);

        // round-robin among all four
        do_reset();
        for (int i = 0; i < NREQ; i++) set_word(i, 32'h11111111 * (i + 1));
        drive(4'b1111, 4'b0000);
        see("rr_c1", 4'b0001, 32'h11111111, 0);
        drive(4'b1111, 4'b0000);
        see("rr_c2", 4'b0010, 32'h22222222, 0);
        chk("rr_reg1", shreg, 32'h11111111);
        drive(4'b1111, 4'b0000);
        see("rr_c3", 4'b0100, 32'h33333333, 0);
        drive(4'b1111, 4'b0000);
        see("rr_c4", 4'b1000, 32'h44444444, 0);
        drive(4'b1111, 4'b0000);
        see("rr_c5", 4'b0001, 32'h11111111, 0);
        chk("rr_reg4", shreg, 32'h44444444);

        // locked burst capped at MAX_LOCK, then forced release
        do_reset();
        set_word(2, 32'hC0DE0002);
        for (int n = 1; n <= MAX_LOCK; n++) begin
            set_word(0, n);
            drive(4'b0101, 4'b0001);
            see($sformatf("burst_w%0d", n), 4'b0001, n, 1);
        end
        set_word(0, 32'd5);
        drive(4'b0101, 4'b0001);
        see("burst_rel", 4'b0100, 32'hC0DE0002, 0);
        chk("burst_reg", shreg, 32'd4);
        drive(4'b0101, 4'b0001);
        see("burst_again", 4'b0001, 32'd5, 1);

        // locked owner 2 drops req after two writes
        do_reset();
        set_word(2, 32'h22220000);
        set_word(3, 32'h33330000);
        drive(4'b1100, 4'b0100);
        see("drop_c1", 4'b0100, 32'h22220000, 1);
        set_word(2, 32'h22220001);
        drive(4'b1100, 4'b0100);
        see("drop_c2", 4'b0100, 32'h22220001, 1);
        drive(4'b1000, 4'b0100);
        see("drop_c3", 4'b1000, 32'h33330000, 0);

        // lock without req is ignored
        drive(4'b0000, 4'b1111);
        see("lk_nreq1", 4'b0000, 32'h0, 0);
        drive(4'b0000, 4'b1111);
        see("lk_nreq2", 4'b0000, 32'h0, 0);

        // asynchronous reset in the middle of a burst
        set_word(0, 32'hABCD0000);
        set_word(3, 32'h0BADF00D);
        drive(4'b0001, 4'b0001);
        see("mid_lock", 4'b0001, 32'hABCD0000, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_gnt", {28'd0, gnt}, 32'd0);
        chk("mid_wen", {31'd0, wen}, 32'd0);
        chk("mid_wdata", wdata, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(4'b1000, 4'b0000);
        see("post_rst", 4'b1000, 32'h0BADF00D, 0);
        drive(4'b0000, 4'b0000);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
